// File: rtl/dbus_waitmem.sv
// Wait-state data memory for a core data bus: fixed WAITST stall per access,
// byte-lane writes, full-word registered reads, misalignment error pulse.
module dbus_waitmem #(
    parameter int DEPTH  = 1024,
    parameter int WAITST = 2
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        DAS,
    input  logic        DRD,
    input  logic        DWR,
    input  logic [31:0] DADDR,
    input  logic [2:0]  DLEN,
    input  logic [31:0] DATAO,
    output logic [31:0] DATAI,
    output logic        HLT,
    output logic        ERR
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic            req;
    logic            l_wr;
    logic [AW+1:0]   l_addr;
    logic [2:0]      l_len;
    logic [31:0]     l_data;
    logic            op_wr;
    logic [AW+1:0]   op_addr;
    logic [2:0]      op_len;
    logic [31:0]     op_data;
    logic [AW-1:0]   idx;
    logic [3:0]      be;
    logic            mis;
    logic            commit;
    logic            unused_hi;
    logic [3:0][7:0] mem [DEPTH];

    assign req       = DAS & (DRD | DWR);
    assign unused_hi = ^DADDR[31:AW+2];

    // With zero wait states the access completes straight out of IDLE, so the
    // live bus is used; otherwise the copy captured at the IDLE exit edge.
    assign op_wr   = (state == IDLE) ? DWR : l_wr;
    assign op_addr = (state == IDLE) ? DADDR[AW+1:0] : l_addr;
    assign op_len  = (state == IDLE) ? DLEN : l_len;
    assign op_data = (state == IDLE) ? DATAO : l_data;
    assign idx     = op_addr[AW+1:2];

    always_comb begin
        be  = 4'b0000;
        mis = 1'b0;
        case (op_len)
            3'd1: be = 4'b0001 << op_addr[1:0];
            3'd2: begin
                be  = op_addr[1] ? 4'b1100 : 4'b0011;
                mis = op_addr[0];
            end
            3'd4: begin
                be  = 4'b1111;
                mis = (op_addr[1:0] != 2'b00);
            end
            default: mis = 1'b1;
        endcase
    end

    assign commit = (state == IDLE && req && WAITST == 0) ||
                    (state == WAIT && cnt == 4'd0);

    assign HLT = !RES && ((state == IDLE && req) || state == WAIT);

    always_ff @(posedge CLK) begin
        if (RES) begin
            state <= IDLE;
            cnt   <= 4'd0;
            DATAI <= 32'd0;
            ERR   <= 1'b0;
        end else begin
            ERR <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    l_wr   <= DWR;
                    l_addr <= DADDR[AW+1:0];
                    l_len  <= DLEN;
                    l_data <= DATAO;
                    if (WAITST == 0) begin
                        state <= DONE;
                    end else begin
                        state <= WAIT;
                        cnt   <= (WAITST > 0) ? 4'(WAITST - 1) : 4'd0;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= DONE;
                    else             cnt   <= cnt - 4'd1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (commit) begin
                ERR <= mis;
                if (!op_wr) DATAI <= mis ? 32'd0 : mem[idx];
            end
        end
    end

    // Memory has no reset; a reset mid-access simply never reaches commit.
    always_ff @(posedge CLK) begin
        if (!RES && commit && op_wr && !mis) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][i] <= op_data[i*8 +: 8];
        end
    end
endmodule

// File: tb/tb_dbus_waitmem.sv
// Directed bench for dbus_waitmem: WAITST=2 instance for function/reset,
// WAITST=0 instance for back-to-back zero-wait accesses.
module tb_dbus_waitmem;
    logic        CLK = 1'b0;
    logic        RES;
    logic        das2, das0, DRD, DWR;
    logic [31:0] DADDR, DATAO;
    logic [2:0]  DLEN;
    logic [31:0] datai2, datai0;
    logic        hlt2, hlt0, err2, err0;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    dbus_waitmem #(.DEPTH(1024), .WAITST(2)) dut2 (
        .CLK(CLK), .RES(RES), .DAS(das2), .DRD(DRD), .DWR(DWR),
        .DADDR(DADDR), .DLEN(DLEN), .DATAO(DATAO),
        .DATAI(datai2), .HLT(hlt2), .ERR(err2));

    dbus_waitmem #(.DEPTH(1024), .WAITST(0)) dut0 (
        .CLK(CLK), .RES(RES), .DAS(das0), .DRD(DRD), .DWR(DWR),
        .DADDR(DADDR), .DLEN(DLEN), .DATAO(DATAO),
        .DATAI(datai0), .HLT(hlt0), .ERR(err0));

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  len;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        exp_err;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [2:0] len,
                                input logic [31:0] wdata, input logic [31:0] exp, input logic exp_err);
        vec_t v;
        v.wr = wr; v.addr = addr; v.len = len; v.wdata = wdata; v.exp = exp; v.exp_err = exp_err;
        return v;
    endfunction

    // One access on instance sel (0: WAITST=2, 1: WAITST=0), checking stall length,
    // the ERR pulse and read data in the DONE cycle.
    task automatic access(input int sel, input vec_t v, input int lat, input string tag);
        int n;
        @(posedge CLK); #1;
        chk({tag, "_err_idle"}, {31'd0, (sel == 0) ? err2 : err0}, 32'd0);
        DADDR = v.addr; DLEN = v.len; DATAO = v.wdata;
        DWR = v.wr; DRD = !v.wr;
        if (sel == 0) das2 = 1'b1; else das0 = 1'b1;
        #1;
        n = 0;
        while (((sel == 0) ? hlt2 : hlt0) && n < 20) begin
            n++;
            @(posedge CLK); #1;
        end
        chk({tag, "_hlt_cycles"}, n, lat);
        chk({tag, "_err"}, {31'd0, (sel == 0) ? err2 : err0}, {31'd0, v.exp_err});
        if (!v.wr) chk({tag, "_data"}, (sel == 0) ? datai2 : datai0, v.exp);
        das2 = 1'b0; das0 = 1'b0;
    endtask

    initial begin
        int n;
        vecs[0]  = mk(1, 32'h10,   3'd4, 32'hDEADBEEF, 0, 0);
        vecs[1]  = mk(0, 32'h10,   3'd4, 0, 32'hDEADBEEF, 0);
        vecs[2]  = mk(1, 32'h20,   3'd4, 32'h11223344, 0, 0);
        vecs[3]  = mk(1, 32'h21,   3'd1, 32'h0000AA00, 0, 0);
        vecs[4]  = mk(0, 32'h20,   3'd4, 0, 32'h1122AA44, 0);
        vecs[5]  = mk(1, 32'h23,   3'd2, 32'hFFFF0000, 0, 1);
        vecs[6]  = mk(0, 32'h20,   3'd4, 0, 32'h1122AA44, 0);
        vecs[7]  = mk(0, 32'h22,   3'd4, 0, 32'h0, 1);
        vecs[8]  = mk(1, 32'h1004, 3'd4, 32'h00000055, 0, 0);
        vecs[9]  = mk(0, 32'h4,    3'd4, 0, 32'h00000055, 0);
        vecs[10] = mk(1, 32'h22,   3'd2, 32'hBEEF0000, 0, 0);
        vecs[11] = mk(0, 32'h20,   3'd4, 0, 32'hBEEFAA44, 0);
        vecs[12] = mk(1, 32'h20,   3'd3, 32'hFFFFFFFF, 0, 1);
        vecs[13] = mk(0, 32'h20,   3'd5, 0, 32'h0, 1);
        vecs[14] = mk(0, 32'h12,   3'd2, 0, 32'hDEADBEEF, 0);
        vecs[15] = mk(1, 32'h30,   3'd4, 32'hCAFEF00D, 0, 0);
        vecs[16] = mk(0, 32'h30,   3'd4, 0, 32'hCAFEF00D, 0);

        RES = 1'b1; das2 = 1'b1; das0 = 1'b1; DRD = 1'b1; DWR = 1'b0;
        DADDR = 0; DLEN = 3'd4; DATAO = 0;
        #1;
        chk("hlt_forced_in_reset", {31'd0, hlt2}, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_datai", datai2, 32'd0);
        chk("reset_err", {31'd0, err2}, 32'd0);
        chk("reset_hlt0", {31'd0, hlt0}, 32'd0);
        das2 = 1'b0; das0 = 1'b0; RES = 1'b0;

        for (int i = 0; i < 17; i++) access(0, vecs[i], 3, $sformatf("vec%0d", i));

        // Reset in the second WAIT cycle aborts a write to 0x30.
        @(posedge CLK); #1;
        DADDR = 32'h30; DLEN = 3'd4; DATAO = 32'h12345678; DWR = 1'b1; DRD = 1'b0; das2 = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("abort_hlt_wait2", {31'd0, hlt2}, 32'd1);
        RES = 1'b1;
        #1;
        chk("abort_hlt_in_reset", {31'd0, hlt2}, 32'd0);
        @(posedge CLK); #1;
        RES = 1'b0; das2 = 1'b0;
        #1;
        chk("abort_datai_cleared", datai2, 32'd0);
        chk("abort_hlt_after", {31'd0, hlt2}, 32'd0);
        access(0, mk(0, 32'h30, 3'd4, 0, 32'hCAFEF00D, 0), 3, "abort_readback");

        // Held read across a reset restarts with full latency.
        @(posedge CLK); #1;
        DADDR = 32'h10; DLEN = 3'd4; DWR = 1'b0; DRD = 1'b1; das2 = 1'b1;
        @(posedge CLK); #1;
        RES = 1'b1;
        @(posedge CLK); #1;
        RES = 1'b0;
        #1;
        n = 0;
        while (hlt2 && n < 20) begin
            n++;
            @(posedge CLK); #1;
        end
        chk("restart_hlt_cycles", n, 3);
        chk("restart_data", datai2, 32'hDEADBEEF);
        das2 = 1'b0;

        // Zero wait states: HLT 1,0 per access, back to back.
        access(1, mk(1, 32'h0, 3'd4, 32'hA5A5A5A5, 0, 0), 1, "z_w0");
        access(1, mk(1, 32'h4, 3'd4, 32'h5A5A5A5A, 0, 0), 1, "z_w4");
        access(1, mk(0, 32'h0, 3'd4, 0, 32'hA5A5A5A5, 0), 1, "z_r0");
        access(1, mk(0, 32'h4, 3'd4, 0, 32'h5A5A5A5A, 0), 1, "z_r4");
        access(1, mk(0, 32'h1, 3'd4, 0, 32'h0, 1), 1, "z_mis");
        @(posedge CLK); #1;
        chk("z_err_cleared", {31'd0, err0}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dbus_waitmem.md
DBUS_WAITMEM -- requirements
Module: dbus_waitmem

Interface
REQ-001 SHALL provide parameter DEPTH, default 1024, meaning the number of 32-bit memory words; it SHALL be a power of two.
REQ-002 SHALL provide parameter WAITST, default 2, meaning the number of wait states per access, legal range 0..15.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 CLK  in  1  clock; all state changes on the rising edge.
REQ-005 RES  in  1  synchronous active-high reset.
REQ-006 DAS  in  1  data access strobe from the core.
REQ-007 DRD  in  1  read request, qualified by DAS.
REQ-008 DWR  in  1  write request, qualified by DAS.
REQ-009 DADDR  in  32  byte address.
REQ-010 DLEN  in  3  access size: 1 = byte, 2 = half, 4 = word.
REQ-011 DATAO  in  32  write data from the core, lane-aligned.
REQ-012 DATAI  out  32  read data to the core, full word.
REQ-013 HLT  out  1  core stall request.
REQ-014 ERR  out  1  one-cycle misaligned-access pulse.

Function
REQ-015 A request SHALL be DAS=1 with DRD=1 or DWR=1; DRD=DWR=1 SHALL be treated as a write.
REQ-016 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-017 IDLE SHALL move to WAIT on a request when WAITST>0, and to DONE when WAITST=0; with no request it SHALL stay in IDLE.
REQ-018 On entry to WAIT, a 4-bit counter SHALL load WAITST-1.
REQ-019 WAIT SHALL decrement the counter each cycle and move to DONE in the cycle after the counter reads 0.
REQ-020 DONE SHALL move to IDLE unconditionally after one cycle.
REQ-021 HLT SHALL be combinational: 1 when (IDLE and request) or WAIT, otherwise 0.
REQ-022 HLT SHALL be 0 in DONE, so that the core completes the access in that cycle.
REQ-023 From request presentation to the first cycle with HLT=0 SHALL take exactly WAITST+1 cycles.
REQ-024 The core SHALL hold DADDR, DLEN, DATAO and the request stable while HLT=1; the block SHALL sample them at the IDLE exit edge.
REQ-025 The word index SHALL be DADDR[log2(DEPTH)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH.
REQ-026 Byte-enable mapping:
  - DLEN=1: enable lane DADDR[1:0].
  - DLEN=2: enable lanes {DADDR[1],0} and {DADDR[1],1}.
  - DLEN=4: enable all four lanes.
  - Any other DLEN value: no lanes enabled.
REQ-027 A write SHALL update only the enabled byte lanes, on the edge that enters DONE.
REQ-028 A read SHALL register the full addressed word into DATAI on the edge that enters DONE.
REQ-029 DATAI SHALL hold its value until the next read completes.
REQ-030 An access SHALL be misaligned when DLEN=2 with DADDR[0]=1, when DLEN=4 with DADDR[1:0]≠0, or when DLEN is illegal.
REQ-031 A misaligned access SHALL still follow the full FSM timing.
REQ-032 A misaligned access SHALL write nothing, load DATAI=0 if it is a read, and assert ERR for exactly the DONE cycle.
REQ-033 A new request arriving in the cycle directly after DONE SHALL be accepted from IDLE with no bubble beyond REQ-023.

Reset
REQ-034 With RES=1 at a clock edge, the block SHALL set state=IDLE, counter=0, DATAI=0 and ERR=0.
REQ-035 While RES=1, HLT SHALL be forced to 0.
REQ-036 Reset SHALL NOT clear memory contents.
REQ-037 Reset asserted in WAIT SHALL abort the access: no write committed, DATAI=0.
REQ-038 After RES deasserts, a held request SHALL restart from IDLE with full WAITST latency.

Verification
REQ-039 WAITST=2, write word 0xDEADBEEF to 0x10 -> HLT=1 for 3 cycles, then 0 for 1 cycle; a later word read of 0x10 returns 0xDEADBEEF with the same timing.
REQ-040 Word 0x11223344 at 0x20, then byte write DATAO=0x0000AA00 at 0x21 (DLEN=1) -> a word read of 0x20 returns 0x1122AA44.
REQ-041 Halfword write at 0x23 -> ERR=1 in the DONE cycle only, memory unchanged; a word read at 0x22 -> ERR=1 and DATAI=0.
REQ-042 WAITST=0, back-to-back reads of 0x0 and 0x4 -> HLT pattern 1,0,1,0, and DATAI updates on each DONE.
REQ-043 DEPTH=1024, write 0x55 to 0x1004 -> a read of 0x4 returns 0x55 (address wrap).
REQ-044 Write to 0x30 with RES pulsed in the second WAIT cycle -> HLT drops to 0, and a read of 0x30 returns the prior contents.
